// File: rtl/rf_bypass_mp.sv
// rtl/rf_bypass_mp.sv - multi-port register file with write-before-read bypass and write-conflict flags
module rf_bypass_mp #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_READ*ADDR_W-1:0]   readRegSel,
    output logic [NUM_READ*DATA_W-1:0]   readOutData,
    input  logic [ADDR_W-1:0]            writeARegSel,
    input  logic [DATA_W-1:0]            writeAInData,
    input  logic                         writeAEn,
    input  logic [ADDR_W-1:0]            writeBRegSel,
    input  logic [DATA_W-1:0]            writeBInData,
    input  logic                         writeBEn,
    output logic                         err,
    output logic                         errSticky
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam bit          ZERO_EN  = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              err_sticky_q;
    logic              err_sticky_d;

    // A write aimed at a hardwired-zero register is treated as if it never happened,
    // both for storage and for bypass.
    logic              wr_a_ok;
    logic              wr_b_ok;
    logic              same_sel;
    logic              conflict;

    logic [ADDR_W-1:0] rd_sel  [NUM_READ];
    logic [DATA_W-1:0] rd_data [NUM_READ];

    // Qualify each write port and detect a same-register collision between the two lanes
    always_comb begin
        wr_a_ok  = writeAEn && !(ZERO_EN && (writeARegSel == '0));
        wr_b_ok  = writeBEn && !(ZERO_EN && (writeBRegSel == '0));
        same_sel = (writeARegSel == writeBRegSel);
        conflict = wr_a_ok && wr_b_ok && same_sel && !rst;
    end

    assign err       = conflict;
    assign errSticky = err_sticky_q;

    // Next-state storage: lane B is the younger instruction, so it is applied last and wins
    always_comb begin
        regs_d = regs_q;
        if (wr_a_ok) begin
            regs_d[writeARegSel] = writeAInData;
        end
        if (wr_b_ok) begin
            regs_d[writeBRegSel] = writeBInData;
        end
    end

    // The sticky flag latches any cycle that saw a collision
    always_comb begin
        err_sticky_d = err_sticky_q | conflict;
    end

    // Storage and sticky flag; reset overrides any write presented in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            err_sticky_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Per-port read mux: B bypass, then A bypass, then storage; reset and reg 0 force zero
    always_comb begin
        readOutData = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_sel[i]  = readRegSel[i*ADDR_W +: ADDR_W];
            rd_data[i] = regs_q[rd_sel[i]];
            if (wr_b_ok && (writeBRegSel == rd_sel[i])) begin
                rd_data[i] = writeBInData;
            end else if (wr_a_ok && (writeARegSel == rd_sel[i])) begin
                rd_data[i] = writeAInData;
            end
            if (rst || (ZERO_EN && (rd_sel[i] == '0))) begin
                rd_data[i] = '0;
            end
            readOutData[i*DATA_W +: DATA_W] = rd_data[i];
        end
    end

endmodule

// File: tb/tb_rf_bypass_mp.sv
// tb/tb_rf_bypass_mp.sv - randomized and directed check of rf_bypass_mp against a behavioural model
module tb_rf_bypass_mp;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 3;
    localparam int NREGS = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR*AW-1:0] rsel = '0;
    logic [AW-1:0]   asel = '0;
    logic [DW-1:0]   adata = '0;
    logic            aen = 1'b0;
    logic [AW-1:0]   bsel = '0;
    logic [DW-1:0]   bdata = '0;
    logic            ben = 1'b0;

    logic [NR*DW-1:0] rd0, rd1;
    logic             err0, err1, stk0, stk1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rf_bypass_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .readRegSel(rsel), .readOutData(rd0),
        .writeARegSel(asel), .writeAInData(adata), .writeAEn(aen),
        .writeBRegSel(bsel), .writeBInData(bdata), .writeBEn(ben),
        .err(err0), .errSticky(stk0)
    );

    rf_bypass_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .readRegSel(rsel), .readOutData(rd1),
        .writeARegSel(asel), .writeAInData(adata), .writeAEn(aen),
        .writeBRegSel(bsel), .writeBInData(bdata), .writeBEn(ben),
        .err(err1), .errSticky(stk1)
    );

    // Reference model: one register array and sticky bit per build (index = ZERO_REG)
    logic [DW-1:0] m_mem [2][NREGS];
    bit            m_stk [2];

    initial begin
        for (int z = 0; z < 2; z++) begin
            m_stk[z] = 1'b0;
            for (int r = 0; r < NREGS; r++) m_mem[z][r] = '0;
        end
    end

    function automatic bit m_wr_ok(int z, logic en, logic [AW-1:0] s);
        return en && !(z == 1 && s == 0);
    endfunction

    function automatic bit m_err(int z);
        if (rst) return 1'b0;
        return m_wr_ok(z, aen, asel) && m_wr_ok(z, ben, bsel) && (asel == bsel);
    endfunction

    function automatic logic [DW-1:0] m_read(int z, logic [AW-1:0] s);
        if (rst) return '0;
        if (z == 1 && s == 0) return '0;
        if (m_wr_ok(z, ben, bsel) && bsel == s) return bdata;
        if (m_wr_ok(z, aen, asel) && asel == s) return adata;
        return m_mem[z][s];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model on each clock edge from the inputs presented in that cycle
    always @(posedge clk) begin
        for (int z = 0; z < 2; z++) begin
            if (rst) begin
                m_stk[z] = 1'b0;
                for (int r = 0; r < NREGS; r++) m_mem[z][r] = '0;
            end else begin
                if (m_err(z)) m_stk[z] = 1'b1;
                if (m_wr_ok(z, aen, asel)) m_mem[z][asel] = adata;
                if (m_wr_ok(z, ben, bsel)) m_mem[z][bsel] = bdata;
            end
        end
    end

    // Compare every output of both builds against the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("rd0_p%0d", i), 32'(rd0[i*DW +: DW]), 32'(m_read(0, rsel[i*AW +: AW])));
                chk($sformatf("rd1_p%0d", i), 32'(rd1[i*DW +: DW]), 32'(m_read(1, rsel[i*AW +: AW])));
            end
            chk("err0", 32'(err0), 32'(m_err(0)));
            chk("err1", 32'(err1), 32'(m_err(1)));
            chk("stk0", 32'(stk0), 32'(m_stk[0]));
            chk("stk1", 32'(stk1), 32'(m_stk[1]));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        aen = 1'b0; ben = 1'b0;
    endtask

    function automatic logic [NR*AW-1:0] sels(int s0, int s1, int s2);
        logic [NR*AW-1:0] v;
        v = '0;
        v[0*AW +: AW] = AW'(s0);
        v[1*AW +: AW] = AW'(s1);
        v[2*AW +: AW] = AW'(s2);
        return v;
    endfunction

    initial begin
        // Reset for two edges, then read every register on every port
        rst = 1'b1; idle();
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            rsel = sels(r, r, r);
            settle();
            chk("rst_rd0", 32'(rd0), 32'(0));
            chk("rst_rd1", 32'(rd1), 32'(0));
            chk("rst_err", 32'({err0, err1}), 32'(0));
            chk("rst_stk", 32'({stk0, stk1}), 32'(0));
            next_cycle();
        end

        // Zero-cycle read-after-write bypass, then the stored value
        aen = 1'b1; asel = 3; adata = 16'hBEEF;
        rsel = sels(3, 4, 3);
        settle();
        chk("byp_p0", 32'(rd0[0 +: DW]), 32'h0000BEEF);
        chk("byp_p1", 32'(rd0[DW +: DW]), 32'h0);
        next_cycle();
        idle();
        settle();
        chk("stored_p0", 32'(rd0[0 +: DW]), 32'h0000BEEF);
        next_cycle();

        // Same-register collision: B wins, sticky latches
        aen = 1'b1; asel = 5; adata = 16'h1111;
        ben = 1'b1; bsel = 5; bdata = 16'h2222;
        rsel = sels(5, 5, 0);
        settle();
        chk("cf_err", 32'(err0), 32'h1);
        chk("cf_byp", 32'(rd0[0 +: DW]), 32'h2222);
        next_cycle();
        idle();
        settle();
        chk("cf_stored", 32'(rd0[DW +: DW]), 32'h2222);
        chk("cf_err_next", 32'(err0), 32'h0);
        chk("cf_sticky", 32'(stk0), 32'h1);
        next_cycle();
        next_cycle();
        chk("cf_sticky_hold", 32'(stk0), 32'h1);

        // Dual write to distinct registers
        aen = 1'b1; asel = 1; adata = 16'h00AA;
        ben = 1'b1; bsel = 2; bdata = 16'h00BB;
        settle();
        chk("dual_err", 32'(err0), 32'h0);
        next_cycle();
        idle();
        rsel = sels(1, 2, 1);
        settle();
        chk("dual_r1", 32'(rd0[0 +: DW]), 32'h00AA);
        chk("dual_r2", 32'(rd0[DW +: DW]), 32'h00BB);
        next_cycle();

        // Register 0 hardwired to zero in the ZERO_REG build
        aen = 1'b1; asel = 0; adata = 16'hFFFF;
        ben = 1'b1; bsel = 0; bdata = 16'hFFFF;
        rsel = sels(0, 0, 0);
        settle();
        chk("z_err", 32'(err1), 32'h0);
        chk("z_byp", 32'(rd1[0 +: DW]), 32'h0);
        chk("z_plain_byp", 32'(rd0[0 +: DW]), 32'hFFFF);
        next_cycle();
        idle();
        settle();
        chk("z_after", 32'(rd1), 32'h0);
        chk("z_plain_after", 32'(rd0[0 +: DW]), 32'hFFFF);
        next_cycle();

        // Reset coincident with a write
        rst = 1'b1;
        aen = 1'b1; asel = 7; adata = 16'h1234;
        rsel = sels(7, 7, 7);
        settle();
        chk("rm_rd", 32'(rd0), 32'h0);
        chk("rm_err", 32'(err0), 32'h0);
        next_cycle();
        rst = 1'b0; idle();
        settle();
        chk("rm_r7", 32'(rd0[0 +: DW]), 32'h0);
        chk("rm_sticky", 32'(stk0), 32'h0);
        next_cycle();

        // Randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 63) == 0);
            aen   = $urandom_range(0, 1);
            ben   = $urandom_range(0, 1);
            asel  = AW'($urandom_range(0, NREGS - 1));
            bsel  = ($urandom_range(0, 3) == 0) ? asel : AW'($urandom_range(0, NREGS - 1));
            adata = DW'($urandom);
            bdata = DW'($urandom);
            for (int i = 0; i < NR; i++) begin
                case ($urandom_range(0, 3))
                    0:       rsel[i*AW +: AW] = asel;
                    1:       rsel[i*AW +: AW] = bsel;
                    default: rsel[i*AW +: AW] = AW'($urandom_range(0, NREGS - 1));
                endcase
            end
            next_cycle();
        end

        rst = 1'b0; idle();
        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
